// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, state and strobe definitions for the control sequencer.
// Pure definitions: no latency and no backpressure.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ADD_OP_DEF = 5'b00011;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_HALT, C_NOP
  } op_class_t;

  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic rd;
    logic wr;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic zlow_out;
    logic c_out;
    logic con_in;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
  } strobes_t;

  // Undefined opcodes fall into C_NOP so they retire after T3.
  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: op_class = C_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:                      op_class = C_IMM;
      OP_LDI:                                        op_class = C_LDI;
      OP_LD:                                         op_class = C_LD;
      OP_ST:                                         op_class = C_ST;
      OP_BR:                                         op_class = C_BR;
      OP_HALT:                                       op_class = C_HALT;
      default:                                       op_class = C_NOP;
    endcase
  endfunction

  function automatic state_t last_step(input op_class_t c);
    case (c)
      C_ALU, C_IMM, C_LDI: last_step = S_T5;
      C_LD, C_ST:          last_step = S_T7;
      C_BR:                last_step = S_T6;
      default:             last_step = S_T3;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map of (state, opcode, con_ff) to datapath strobes and alu_op.
// Zero latency, no backpressure.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter logic [4:0] ADD_OP = ADD_OP_DEF
) (
  input  state_t     i_state,
  input  logic [4:0] i_opcode,
  input  logic       i_con_ff,
  output strobes_t   o_strb,
  output logic [4:0] o_alu_op
);

  op_class_t w_cls;
  assign w_cls = op_class(i_opcode);

  always_comb begin
    o_strb   = '0;
    o_alu_op = '0;
    case (i_state)
      S_T0: begin
        o_strb.pc_out = 1'b1;
        o_strb.mar_in = 1'b1;
        o_strb.inc_pc = 1'b1;
        o_strb.z_in   = 1'b1;
      end
      S_T1: begin
        o_strb.zlow_out = 1'b1;
        o_strb.pc_in    = 1'b1;
        o_strb.rd       = 1'b1;
        o_strb.mdr_in   = 1'b1;
      end
      S_T2: begin
        o_strb.mdr_out = 1'b1;
        o_strb.ir_in   = 1'b1;
      end
      S_T3: begin
        case (w_cls)
          C_ALU, C_IMM: begin
            o_strb.grb   = 1'b1;
            o_strb.r_out = 1'b1;
            o_strb.y_in  = 1'b1;
          end
          C_LDI, C_LD, C_ST: begin
            o_strb.grb    = 1'b1;
            o_strb.ba_out = 1'b1;
            o_strb.y_in   = 1'b1;
          end
          C_BR: begin
            o_strb.gra    = 1'b1;
            o_strb.r_out  = 1'b1;
            o_strb.con_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (w_cls)
          C_ALU: begin
            o_strb.grc   = 1'b1;
            o_strb.r_out = 1'b1;
            o_strb.z_in  = 1'b1;
            o_alu_op     = i_opcode;
          end
          C_IMM: begin
            o_strb.c_out = 1'b1;
            o_strb.z_in  = 1'b1;
            o_alu_op     = i_opcode;
          end
          C_LDI, C_LD, C_ST: begin
            o_strb.c_out = 1'b1;
            o_strb.z_in  = 1'b1;
            o_alu_op     = ADD_OP;
          end
          C_BR: begin
            o_strb.pc_out = 1'b1;
            o_strb.y_in   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (w_cls)
          C_ALU, C_IMM, C_LDI: begin
            o_strb.zlow_out = 1'b1;
            o_strb.gra      = 1'b1;
            o_strb.r_in     = 1'b1;
          end
          C_LD, C_ST: begin
            o_strb.zlow_out = 1'b1;
            o_strb.mar_in   = 1'b1;
          end
          C_BR: begin
            o_strb.c_out = 1'b1;
            o_strb.z_in  = 1'b1;
            o_alu_op     = ADD_OP;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (w_cls)
          C_LD: begin
            o_strb.rd     = 1'b1;
            o_strb.mdr_in = 1'b1;
          end
          C_ST: begin
            o_strb.gra    = 1'b1;
            o_strb.r_out  = 1'b1;
            o_strb.mdr_in = 1'b1;
          end
          C_BR: begin
            o_strb.zlow_out = i_con_ff;
            o_strb.pc_in    = i_con_ff;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (w_cls)
          C_LD: begin
            o_strb.mdr_out = 1'b1;
            o_strb.gra     = 1'b1;
            o_strb.r_in    = 1'b1;
          end
          C_ST: o_strb.wr = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: one micro-step per clock, Moore outputs.
// Memory steps stall on mem_ready when MEM_WAIT_EN=1; stop halts at the next instruction boundary.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [4:0] ADD_OP      = ADD_OP_DEF,
  parameter bit         MEM_WAIT_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] ir_opcode,
  input  logic       con_ff,
  input  logic       mem_ready,
  input  logic       stop,
  output logic       PCout,
  output logic       PCin,
  output logic       IncPC,
  output logic       MARin,
  output logic       MDRin,
  output logic       MDRout,
  output logic       Read,
  output logic       Write,
  output logic       IRin,
  output logic       Yin,
  output logic       Zin,
  output logic       Zlowout,
  output logic       Cout,
  output logic       CONin,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       Rin,
  output logic       Rout,
  output logic       BAout,
  output logic [4:0] alu_op,
  output logic       run
);

  state_t    r_state;
  op_class_t w_cls;
  strobes_t  w_strb;
  logic      w_last;
  logic      w_mem_step;
  logic      w_hold;

  assign w_cls      = op_class(ir_opcode);
  assign w_last     = (r_state == last_step(w_cls));
  assign w_mem_step = (r_state == S_T1)
                    || (r_state == S_T6 && w_cls == C_LD)
                    || (r_state == S_T7 && w_cls == C_ST);
  assign w_hold     = MEM_WAIT_EN && w_mem_step && !mem_ready;

  // A pending wait takes priority over the boundary, so st T7 samples stop only when it retires.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_RST;
    end else begin
      case (r_state)
        S_RST:  r_state <= S_T0;
        S_HALT: r_state <= S_HALT;
        default: begin
          if (w_hold)
            r_state <= r_state;
          else if (r_state == S_T3 && w_cls == C_HALT)
            r_state <= S_HALT;
          else if (w_last)
            r_state <= stop ? S_HALT : S_T0;
          else
            r_state <= state_t'(r_state + 4'd1);
        end
      endcase
    end
  end

  ctrl_decode #(.ADD_OP(ADD_OP)) u_decode (
    .i_state  (r_state),
    .i_opcode (ir_opcode),
    .i_con_ff (con_ff),
    .o_strb   (w_strb),
    .o_alu_op (alu_op)
  );

  assign PCout   = w_strb.pc_out;
  assign PCin    = w_strb.pc_in;
  assign IncPC   = w_strb.inc_pc;
  assign MARin   = w_strb.mar_in;
  assign MDRin   = w_strb.mdr_in;
  assign MDRout  = w_strb.mdr_out;
  assign Read    = w_strb.rd;
  assign Write   = w_strb.wr;
  assign IRin    = w_strb.ir_in;
  assign Yin     = w_strb.y_in;
  assign Zin     = w_strb.z_in;
  assign Zlowout = w_strb.zlow_out;
  assign Cout    = w_strb.c_out;
  assign CONin   = w_strb.con_in;
  assign Gra     = w_strb.gra;
  assign Grb     = w_strb.grb;
  assign Grc     = w_strb.grc;
  assign Rin     = w_strb.r_in;
  assign Rout    = w_strb.r_out;
  assign BAout   = w_strb.ba_out;
  assign run     = (r_state != S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed and randomized checks of the control sequencer strobe sequences.
module tb_control_sequencer;

  logic       clock;
  logic       reset_n;
  logic [4:0] ir_opcode;
  logic       con_ff;
  logic       mem_ready;
  logic       stop;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin;
  logic Zin, Zlowout, Cout, CONin, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] alu_op;
  logic       run;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [19:0] M_PCOUT  = 20'h80000;
  localparam logic [19:0] M_PCIN   = 20'h40000;
  localparam logic [19:0] M_INCPC  = 20'h20000;
  localparam logic [19:0] M_MARIN  = 20'h10000;
  localparam logic [19:0] M_MDRIN  = 20'h08000;
  localparam logic [19:0] M_MDROUT = 20'h04000;
  localparam logic [19:0] M_READ   = 20'h02000;
  localparam logic [19:0] M_WRITE  = 20'h01000;
  localparam logic [19:0] M_IRIN   = 20'h00800;
  localparam logic [19:0] M_YIN    = 20'h00400;
  localparam logic [19:0] M_ZIN    = 20'h00200;
  localparam logic [19:0] M_ZLO    = 20'h00100;
  localparam logic [19:0] M_COUT   = 20'h00080;
  localparam logic [19:0] M_CONIN  = 20'h00040;
  localparam logic [19:0] M_GRA    = 20'h00020;
  localparam logic [19:0] M_GRB    = 20'h00010;
  localparam logic [19:0] M_GRC    = 20'h00008;
  localparam logic [19:0] M_RIN    = 20'h00004;
  localparam logic [19:0] M_ROUT   = 20'h00002;
  localparam logic [19:0] M_BAOUT  = 20'h00001;

  localparam logic [19:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [19:0] F1 = M_ZLO | M_PCIN | M_READ | M_MDRIN;
  localparam logic [19:0] F2 = M_MDROUT | M_IRIN;
  localparam logic [19:0] BUS_MASK = M_PCOUT | M_MDROUT | M_ZLO | M_ROUT | M_BAOUT | M_COUT;
  localparam logic [19:0] GR_MASK  = M_GRA | M_GRB | M_GRC;

  control_sequencer dut (
    .clock(clock), .reset_n(reset_n), .ir_opcode(ir_opcode), .con_ff(con_ff),
    .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .alu_op(alu_op), .run(run)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [19:0] obs();
    obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin,
           Zin, Zlowout, Cout, CONin, Gra, Grb, Grc, Rin, Rout, BAout};
  endfunction

  function automatic int base_len(input logic [4:0] op);
    case (op)
      5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
      5'b01100, 5'b01101, 5'b01110: base_len = 6;
      5'b00000, 5'b00010:           base_len = 8;
      5'b10010:                     base_len = 7;
      default:                      base_len = 4;
    endcase
  endfunction

  function automatic int mem_steps(input logic [4:0] op);
    mem_steps = (op == 5'b00000 || op == 5'b00010) ? 2 : 1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({obs(), alu_op, run} !== {20'h0, 5'h0, 1'b1}) begin
        n_err++;
        $display("FAIL reset[%0d]: got strb=%h alu=%h run=%b, want strb=00000 alu=00 run=1",
                 i, obs(), alu_op, run);
      end
      tick();
    end
  endtask

  task automatic test_andi();
    logic [19:0] e [7];
    logic [4:0]  a [7];
    e = '{F0, F1, F2, M_GRB | M_ROUT | M_YIN, M_COUT | M_ZIN, M_ZLO | M_GRA | M_RIN, F0};
    a = '{5'h0, 5'h0, 5'h0, 5'h0, 5'b01101, 5'h0, 5'h0};
    ir_opcode = 5'b01101;
    mem_ready = 1'b1;
    reset_n   = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      n_vec++;
      if ({obs(), alu_op, run} !== {e[i], a[i], 1'b1}) begin
        n_err++;
        $display("FAIL andi step %0d: got strb=%h alu=%h run=%b, want strb=%h alu=%h run=1",
                 i, obs(), alu_op, run, e[i], a[i]);
      end
      if (i < 6) tick();
    end
  endtask

  task automatic test_ld_wait();
    logic [19:0] e [12];
    logic [4:0]  a [12];
    bit          mr [12];
    e = '{F0, F1, F2, M_GRB | M_BAOUT | M_YIN, M_COUT | M_ZIN, M_ZLO | M_MARIN,
          M_READ | M_MDRIN, M_READ | M_MDRIN, M_READ | M_MDRIN, M_READ | M_MDRIN,
          M_MDROUT | M_GRA | M_RIN, F0};
    a  = '{5'h0, 5'h0, 5'h0, 5'h0, 5'b00011, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0};
    mr = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    ir_opcode = 5'b00000;
    for (int i = 0; i < 12; i++) begin
      mem_ready = mr[i];
      n_vec++;
      if ({obs(), alu_op, run} !== {e[i], a[i], 1'b1}) begin
        n_err++;
        $display("FAIL ld_wait step %0d: got strb=%h alu=%h run=%b, want strb=%h alu=%h run=1",
                 i, obs(), alu_op, run, e[i], a[i]);
      end
      if (i < 11) tick();
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_br();
    logic [19:0] e [8];
    logic [4:0]  a [8];
    ir_opcode = 5'b10010;
    for (int c = 0; c < 2; c++) begin
      con_ff = (c == 1);
      e = '{F0, F1, F2, M_GRA | M_ROUT | M_CONIN, M_PCOUT | M_YIN, M_COUT | M_ZIN,
            (c == 1) ? (M_ZLO | M_PCIN) : 20'h0, F0};
      a = '{5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'b00011, 5'h0, 5'h0};
      for (int i = 0; i < 8; i++) begin
        n_vec++;
        if ({obs(), alu_op, run} !== {e[i], a[i], 1'b1}) begin
          n_err++;
          $display("FAIL br con_ff=%0d step %0d: got strb=%h alu=%h run=%b, want strb=%h alu=%h run=1",
                   c, i, obs(), alu_op, run, e[i], a[i]);
        end
        if (i < 7) tick();
      end
    end
    con_ff = 1'b0;
  endtask

  task automatic test_stop();
    logic [19:0] e [12];
    logic [4:0]  a [12];
    e = '{F0, F1, F2, M_GRB | M_ROUT | M_YIN, M_GRC | M_ROUT | M_ZIN, M_ZLO | M_GRA | M_RIN,
          20'h0, 20'h0, 20'h0, 20'h0, 20'h0, 20'h0};
    a = '{5'h0, 5'h0, 5'h0, 5'h0, 5'b00011, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0};
    ir_opcode = 5'b00011;
    for (int i = 0; i < 12; i++) begin
      stop = (i >= 4);
      if (i >= 6) mem_ready = i[0];
      n_vec++;
      if ({obs(), alu_op, run} !== {e[i], a[i], (i < 6)}) begin
        n_err++;
        $display("FAIL stop step %0d: got strb=%h alu=%h run=%b, want strb=%h alu=%h run=%b",
                 i, obs(), alu_op, run, e[i], a[i], (i < 6));
      end
      if (i < 11) tick();
    end
    stop      = 1'b0;
    mem_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({obs(), alu_op, run} !== {20'h0, 5'h0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_from_halt: got strb=%h alu=%h run=%b, want strb=00000 alu=00 run=1",
               obs(), alu_op, run);
    end
    reset_n = 1'b1;
    tick();
    n_vec++;
    if ({obs(), run} !== {F0, 1'b1}) begin
      n_err++;
      $display("FAIL t0_after_halt_reset: got strb=%h run=%b, want strb=%h run=1", obs(), run, F0);
    end
    ir_opcode = 5'b11010;
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (obs() !== F1) begin
        n_err++;
        $display("FAIL t1_wait[%0d]: got strb=%h, want strb=%h", i, obs(), F1);
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({obs(), alu_op, run, Read} !== {20'h0, 5'h0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset_mid_wait: got strb=%h alu=%h run=%b read=%b, want strb=00000 alu=00 run=1 read=0",
               obs(), alu_op, run, Read);
    end
    tick();
    n_vec++;
    if ({obs(), run} !== {20'h0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_held: got strb=%h run=%b, want strb=00000 run=1", obs(), run);
    end
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    tick();
    n_vec++;
    if ({obs(), alu_op} !== {F0, 5'h0}) begin
      n_err++;
      $display("FAIL t0_after_release: got strb=%h alu=%h, want strb=%h alu=00", obs(), alu_op, F0);
    end
  endtask

  task automatic test_sweep();
    logic [19:0] w;
    logic [4:0]  cur;
    int          len, rw, exp_len;
    bit          started;
    started = 1'b0;
    cur = 5'b11010;
    len = 0;
    rw  = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      w = obs();
      n_vec++;
      if ($countones(w & BUS_MASK) > 1 || $countones(w & GR_MASK) > 1) begin
        n_err++;
        $display("FAIL exclusivity cyc %0d: got strb=%h op=%b, want at most one bus driver and one Gr*",
                 cyc, w, cur);
      end
      if (w == F0) begin
        if (started) begin
          exp_len = base_len(cur) + rw - mem_steps(cur);
          n_vec++;
          if (len !== exp_len) begin
            n_err++;
            $display("FAIL length op=%b cyc %0d: got %0d cycles, want %0d", cur, cyc, len, exp_len);
          end
        end
        started = 1'b1;
        len = 0;
        rw  = 0;
        cur = 5'($urandom_range(0, 31));
        if (cur == 5'b11011) cur = 5'b11100;
        ir_opcode = cur;
      end
      len++;
      if ((w & (M_READ | M_WRITE)) != 20'h0) rw++;
      con_ff    = 1'($urandom);
      mem_ready = 1'($urandom);
      tick();
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    ir_opcode = 5'h0;
    con_ff    = 1'b0;
    mem_ready = 1'b1;
    stop      = 1'b0;
    #1;
    test_reset();
    test_andi();
    test_ld_wait();
    test_br();
    test_stop();
    test_async_reset();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle control unit that drives the select-and-encode logic and the rest of the datapath.
- Sequences fetch, decode and execute for a subset of the 5-bit-opcode instruction set.
- Issues the register-file selects (Gra/Grb/Grc/Rin/Rout/BAout) and bus, ALU and memory strobes one micro-step per clock.
- Sits between the IR opcode field and the datapath; the select-and-encode block turns its Gr*/R* outputs into the 16-bit register enables.

Parameters:
- ADD_OP, 5'b00011, ALU code driven on alu_op for address and branch-target calculation.
- MEM_WAIT_EN, 1, 1 = hold memory steps until mem_ready; 0 = one cycle per memory step, mem_ready ignored.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ir_opcode  in  5  IR[31:27], stable from T3 onward.
- con_ff  in  1  branch-condition flip-flop output.
- mem_ready  in  1  memory completed the current Read/Write.
- stop  in  1  request halt at the next instruction boundary.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout, Cout, CONin  out  1 each  datapath strobes.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  to select-and-encode.
- alu_op  out  5  ALU function; ir_opcode in ALU-op steps, ADD_OP in address steps, 0 otherwise.
- run  out  1  1 while executing, 0 when halted.

Behaviour:
- Clock and reset: one clock domain; reset_n is asynchronous, active-low.
- Reset state: while reset_n=0 the state is RST. All strobes and alu_op are 0 and run=1. RST goes to T0 on the first clock after release.
- Outputs: Moore-style, decoded from the state register plus ir_opcode. Each state lasts one clock unless it is a wait state.
- Fetch:
  - T0: PCout MARin IncPC Zin.
  - T1: Zlowout PCin Read MDRin.
  - T2: MDRout IRin.
  - T2 goes to T3.
- Reg-reg ALU (add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000):
  - T3: Grb Rout Yin.
  - T4: Grc Rout Zin, alu_op=ir_opcode.
  - T5: Zlowout Gra Rin.
  - Then T0.
- Immediate ALU (addi 01100, andi 01101, ori 01110):
  - T3: Grb Rout Yin.
  - T4: Cout Zin, alu_op=ir_opcode.
  - T5: Zlowout Gra Rin.
- ldi 00001:
  - T3: Grb BAout Yin.
  - T4: Cout Zin, alu_op=ADD_OP.
  - T5: Zlowout Gra Rin.
- ld 00000:
  - T3–T4 same as ldi.
  - T5: Zlowout MARin.
  - T6: Read MDRin.
  - T7: MDRout Gra Rin.
- st 00010:
  - T3–T4 same as ldi.
  - T5: Zlowout MARin.
  - T6: Gra Rout MDRin.
  - T7: Write.
- br 10010:
  - T3: Gra Rout CONin.
  - T4: PCout Yin.
  - T5: Cout Zin, alu_op=ADD_OP.
  - T6: if con_ff=1, Zlowout PCin; else no strobes.
  - Then T0.
- nop 11010 and any undefined opcode: T3 with no strobes, then T0.
- halt 11011: T3 goes to HALT. HALT has all strobes 0 and run=0, and is left only by reset.
- Memory wait (MEM_WAIT_EN=1):
  - Applies to T1, ld T6 and st T7.
  - The step's strobes (Read/MDRin or Write) stay high and the state holds until mem_ready=1 is sampled, then the state advances.
  - mem_ready=1 in the first cycle of the step means one-cycle latency.
  - mem_ready outside a wait state is ignored.
- stop:
  - Sampled only on the last step of an instruction, i.e. the state that would go to T0.
  - If stop=1 there, the next state is HALT instead of T0.
  - stop=1 in any other state has no effect until that boundary.
- Exclusivity: at most one of PCout, MDRout, Zlowout, Rout, BAout, Cout is high in any state, so the bus has a single driver. Gra, Grb and Grc are mutually exclusive.
- Reset mid-operation: reset_n=0 in any state, including memory wait and HALT, forces RST immediately (asynchronously). All outputs drop to their reset values in the same cycle.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams (OP_LD … OP_HALT);
  - state encoding (RST, T0–T7, HALT), 4-bit;
  - ADD_OP default.
- One sub-module, ctrl_decode: combinational mapping of (state, ir_opcode, con_ff) to the strobe vector and alu_op.
- The top-level module holds the state register, wait logic and stop/halt logic.

Test Plan:
- Reset, fetch and andi, mem_ready tied 1: release reset_n; supply ir_opcode=01101 (IR 0x691ffffd, andi R2,R3,-3).
  - Expect T0–T2 fetch strobes.
  - T3: Grb Rout Yin.
  - T4: Cout Zin, alu_op=01101.
  - T5: Zlowout Gra Rin.
  - Back to T0; 6 cycles per instruction.
- ld with memory latency: ir_opcode=00000, mem_ready low 3 cycles in T6.
  - Expect Read MDRin high for 4 cycles, then T7 MDRout Gra Rin.
  - Total 11 cycles from T0.
- br not taken vs taken: ir_opcode=10010.
  - With con_ff=0: T6 has no strobes.
  - With con_ff=1: T6 has Zlowout PCin.
  - In both cases CONin is high only in T3.
- stop timing: assert stop during T4 of an add.
  - Expect T5 completes (Gra Rin), then HALT with run=0.
  - Further clocks and mem_ready toggling have no effect.
- Async reset mid-wait: hold mem_ready=0 in T1 and pulse reset_n low between clock edges.
  - Expect all strobes 0 immediately and Read deasserted.
  - First clock after release goes to T0 with PCout MARin IncPC Zin.
- Bus exclusivity sweep: random opcodes including undefined ones and random con_ff/mem_ready over 10k cycles.
  - Assert at most one bus driver and at most one Gr* per cycle.
  - Undefined opcodes take exactly 4 cycles (T0–T3).
